// File: rtl/vital_monitor.sv
// vital_monitor: clocked multi-channel vital-sign range checker.
// Each accepted sample is compared against a programmable min/max table
// selected by age category; a per-channel alarm latches after PERSIST
// consecutive out-of-range samples and clears on acknowledge.
module vital_monitor #(
    parameter int NCH     = 4,
    parameter int DW      = 8,
    parameter int PERSIST = 4,
    parameter int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       age_category,
    input  logic             sample_valid,
    input  logic [CHW-1:0]   sample_ch,
    input  logic [DW-1:0]    sample_data,
    input  logic             cfg_we,
    input  logic [CHW+2:0]   cfg_addr,
    input  logic [DW-1:0]    cfg_wdata,
    input  logic [NCH-1:0]   ack,
    output logic [NCH-1:0]   normal,
    output logic [NCH-1:0]   alarm,
    output logic             alarm_any
);

    localparam logic [7:0] PERSIST_CNT = 8'(PERSIST);

    // Power-on threshold for (category, channel, sel); sel 0 = min, 1 = max.
    function automatic logic [DW-1:0] default_threshold(input int cat, input int ch,
                                                        input logic sel);
        int v;
        v = 0;
        case (ch)
            0: case (cat)
                   0:       v = sel ? 160 : 100;
                   1:       v = sel ? 120 : 70;
                   default: v = sel ? 100 : 60;
               endcase
            1: v = sel ? 100 : 97;
            2: v = sel ? 100 : 90;
            3: case (cat)
                   0:       v = sel ? 16 : 12;
                   1:       v = sel ? 14 : 10;
                   2:       v = sel ? 9  : 7;
                   default: v = sel ? 10 : 8;
               endcase
            default: v = 0;
        endcase
        if (ch >= 4) begin
            return sel ? '1 : '0;
        end
        return DW'(v);
    endfunction

    logic [DW-1:0]  min_tbl [4][NCH];
    logic [DW-1:0]  max_tbl [4][NCH];

    logic [1:0]     prev_cat;
    logic [NCH-1:0] normal_q, normal_d;
    logic [NCH-1:0] alarm_q, alarm_d;
    logic [7:0]     cnt_q [NCH];
    logic [7:0]     cnt_d [NCH];

    logic [NCH-1:0] hit, in_rng, set_evt;
    logic           age_change;

    logic           cfg_sel;
    logic [CHW-1:0] cfg_ch;
    logic [1:0]     cfg_cat;

    assign cfg_sel    = cfg_addr[0];
    assign cfg_ch     = cfg_addr[CHW:1];
    assign cfg_cat    = cfg_addr[CHW+2:CHW+1];
    assign age_change = (age_category != prev_cat);

    // Threshold table: loads defaults on reset, written one entry per cfg strobe.
    // NOTE: the table is reset on purpose -- rst must restore the default
    // thresholds, so these are plain flops rather than an unreset RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int cat = 0; cat < 4; cat++) begin
                for (int c = 0; c < NCH; c++) begin
                    min_tbl[cat][c] <= default_threshold(cat, c, 1'b0);
                    max_tbl[cat][c] <= default_threshold(cat, c, 1'b1);
                end
            end
        end else if (cfg_we) begin
            for (int c = 0; c < NCH; c++) begin
                if (cfg_ch == CHW'(c)) begin
                    if (cfg_sel) max_tbl[cfg_cat][c] <= cfg_wdata;
                    else         min_tbl[cfg_cat][c] <= cfg_wdata;
                end
            end
        end
    end

    // Per-channel next state: range check, persistence count, alarm set/ack.
    // NOTE: blocking assignments here are intentional -- cnt_d is computed and
    // then read within the same pass; every target gets a default first so no
    // latch is inferred.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            normal_d[c] = normal_q[c];
            cnt_d[c]    = cnt_q[c];
            set_evt[c]  = 1'b0;
            hit[c]      = sample_valid && !age_change && (sample_ch == CHW'(c));
            in_rng[c]   = (sample_data >= min_tbl[age_category][c]) &&
                          (sample_data <= max_tbl[age_category][c]);
            if (age_change) begin
                normal_d[c] = 1'b0;
                cnt_d[c]    = 8'd0;
            end else if (hit[c]) begin
                if (in_rng[c]) begin
                    normal_d[c] = 1'b1;
                    cnt_d[c]    = 8'd0;
                end else begin
                    normal_d[c] = 1'b0;
                    cnt_d[c]    = (cnt_q[c] >= PERSIST_CNT) ? PERSIST_CNT
                                                            : cnt_q[c] + 8'd1;
                    set_evt[c]  = (cnt_d[c] == PERSIST_CNT);
                end
            end
            // A set event wins over a simultaneous acknowledge.
            alarm_d[c] = set_evt[c] | (alarm_q[c] & ~ack[c]);
        end
    end

    // Channel state and previous-category registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            normal_q <= '0;
            alarm_q  <= '0;
            prev_cat <= 2'b00;
            for (int c = 0; c < NCH; c++) begin
                cnt_q[c] <= 8'd0;
            end
        end else begin
            normal_q <= normal_d;
            alarm_q  <= alarm_d;
            prev_cat <= age_category;
            for (int c = 0; c < NCH; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    assign normal    = normal_q;
    assign alarm     = alarm_q;
    assign alarm_any = |alarm_q;

endmodule

// File: tb/tb_vital_monitor.sv
// Directed testbench for vital_monitor (NCH=4, DW=8, PERSIST=4).
module tb_vital_monitor;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int CHW = 2;

    logic           clk;
    logic           rst;
    logic [1:0]     age_category;
    logic           sample_valid;
    logic [CHW-1:0] sample_ch;
    logic [DW-1:0]  sample_data;
    logic           cfg_we;
    logic [CHW+2:0] cfg_addr;
    logic [DW-1:0]  cfg_wdata;
    logic [NCH-1:0] ack;
    logic [NCH-1:0] normal;
    logic [NCH-1:0] alarm;
    logic           alarm_any;

    int vectors;
    int miscompares;

    vital_monitor #(.NCH(NCH), .DW(DW), .PERSIST(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .age_category (age_category),
        .sample_valid (sample_valid),
        .sample_ch    (sample_ch),
        .sample_data  (sample_data),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .ack          (ack),
        .normal       (normal),
        .alarm        (alarm),
        .alarm_any    (alarm_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one sample for one edge.
    task automatic send(input logic [CHW-1:0] ch, input logic [DW-1:0] data);
        sample_valid = 1'b1;
        sample_ch    = ch;
        sample_data  = data;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        age_category = 2'b10;
        sample_valid = 1'b0;
        sample_ch    = '0;
        sample_data  = '0;
        cfg_we       = 1'b0;
        cfg_addr     = '0;
        cfg_wdata    = '0;
        ack          = '0;
        #12;
        vectors++;
        if (normal !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_normal got %b want %b", normal, 4'b0000);
        end
        vectors++;
        if (alarm !== 4'b0000 || alarm_any !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_alarm got %b/%b want 0000/0", alarm, alarm_any);
        end
        rst = 1'b0;
        step();  // registered category moves 00 -> adult
    endtask

    task automatic test_range();
        send(2'd0, 8'd72);
        vectors++;
        if (normal[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL range_72 got %b want 1", normal[0]);
        end
        send(2'd0, 8'd100);
        vectors++;
        if (normal[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL range_100_inclusive got %b want 1", normal[0]);
        end
        send(2'd0, 8'd101);
        vectors++;
        if (normal[0] !== 1'b0 || alarm !== 4'b0000) begin
            miscompares++;
            $display("FAIL range_101 got normal0=%b alarm=%b want 0/0000", normal[0], alarm);
        end
        send(2'd0, 8'd80);  // clear ch0 count
    endtask

    task automatic test_persist();
        send(2'd1, 8'd103);
        send(2'd1, 8'd103);
        send(2'd1, 8'd103);
        send(2'd1, 8'd98);
        vectors++;
        if (normal[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL persist_break_normal got %b want 1", normal[1]);
        end
        send(2'd1, 8'd103);
        vectors++;
        if (alarm !== 4'b0000 || normal[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL persist_interrupted got alarm=%b normal1=%b want 0000/0", alarm, normal[1]);
        end
        send(2'd1, 8'd103);
        send(2'd1, 8'd103);
        vectors++;
        if (alarm[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL persist_count3 got %b want 0", alarm[1]);
        end
        send(2'd1, 8'd103);
        vectors++;
        if (alarm !== 4'b0010 || alarm_any !== 1'b1) begin
            miscompares++;
            $display("FAIL persist_alarm got %b/%b want 0010/1", alarm, alarm_any);
        end
        ack = 4'b0010;
        step();
        ack = 4'b0000;
        vectors++;
        if (alarm !== 4'b0000 || alarm_any !== 1'b0) begin
            miscompares++;
            $display("FAIL persist_ack got %b/%b want 0000/0", alarm, alarm_any);
        end
        send(2'd1, 8'd98);
    endtask

    task automatic test_ack_race();
        for (int i = 0; i < 4; i++) send(2'd2, 8'd85);
        vectors++;
        if (alarm !== 4'b0100) begin
            miscompares++;
            $display("FAIL ack_race_set got %b want 0100", alarm);
        end
        ack = 4'b0100;
        send(2'd2, 8'd85);
        ack = 4'b0000;
        vectors++;
        if (alarm[2] !== 1'b1) begin
            miscompares++;
            $display("FAIL ack_race_set_wins got %b want 1", alarm[2]);
        end
        ack = 4'b0100;
        step();
        ack = 4'b0000;
        vectors++;
        if (alarm[2] !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_race_clear got %b want 0", alarm[2]);
        end
        send(2'd2, 8'd85);
        vectors++;
        if (alarm !== 4'b0100 || alarm_any !== 1'b1) begin
            miscompares++;
            $display("FAIL ack_race_reraise got %b/%b want 0100/1", alarm, alarm_any);
        end
        ack = 4'b0100;
        step();
        ack = 4'b0000;
        send(2'd2, 8'd95);
    endtask

    task automatic test_cfg();
        age_category = 2'b00;
        step();
        vectors++;
        if (normal !== 4'b0000) begin
            miscompares++;
            $display("FAIL cfg_cat_change_normal got %b want 0000", normal);
        end
        // Write infant ch3 max = 20 while an 18 is compared against the old max 16.
        cfg_we    = 1'b1;
        cfg_addr  = {2'b00, 2'd3, 1'b1};
        cfg_wdata = 8'd20;
        send(2'd3, 8'd18);
        cfg_we    = 1'b0;
        vectors++;
        if (normal[3] !== 1'b0) begin
            miscompares++;
            $display("FAIL cfg_same_cycle got %b want 0", normal[3]);
        end
        send(2'd3, 8'd18);
        vectors++;
        if (normal[3] !== 1'b1) begin
            miscompares++;
            $display("FAIL cfg_new_max got %b want 1", normal[3]);
        end
    endtask

    task automatic test_age_change();
        age_category = 2'b10;
        step();
        for (int i = 0; i < 4; i++) send(2'd1, 8'd103);
        send(2'd2, 8'd95);
        for (int i = 0; i < 3; i++) send(2'd0, 8'd150);
        vectors++;
        if (alarm !== 4'b0010 || normal !== 4'b0100) begin
            miscompares++;
            $display("FAIL age_pre got alarm=%b normal=%b want 0010/0100", alarm, normal);
        end
        // Category change with a sample in the same cycle: sample is discarded.
        age_category = 2'b01;
        send(2'd0, 8'd150);
        vectors++;
        if (normal !== 4'b0000 || alarm !== 4'b0010) begin
            miscompares++;
            $display("FAIL age_change got normal=%b alarm=%b want 0000/0010", normal, alarm);
        end
        for (int i = 0; i < 3; i++) send(2'd0, 8'd150);
        vectors++;
        if (alarm[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL age_count_cleared got %b want 0", alarm[0]);
        end
        send(2'd0, 8'd150);
        vectors++;
        if (alarm !== 4'b0011) begin
            miscompares++;
            $display("FAIL age_realarm got %b want 0011", alarm);
        end
    endtask

    task automatic test_async_reset();
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (alarm !== 4'b0000 || alarm_any !== 1'b0 || normal !== 4'b0000) begin
            miscompares++;
            $display("FAIL async_reset got alarm=%b any=%b normal=%b want 0000/0/0000",
                     alarm, alarm_any, normal);
        end
        #1;
        rst = 1'b0;
        age_category = 2'b10;
        step();
        send(2'd0, 8'd61);
        vectors++;
        if (normal[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset_adult_ecg got %b want 1", normal[0]);
        end
        age_category = 2'b00;
        step();
        send(2'd3, 8'd18);
        vectors++;
        if (normal[3] !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset_table got %b want 0", normal[3]);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_range();
        test_persist();
        test_ack_race();
        test_cfg();
        test_age_change();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
